// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: FSM states, funct3 encodings and the access legality check.
// Pure declarations; no latency or backpressure of its own.
package lsu_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } lsu_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Unsigned variants exist only for loads; alignment follows the access size.
  function automatic logic lsu_access_err(input logic we, input logic [2:0] funct3,
                                          input logic [1:0] addr_lo);
    logic legal;
    logic mis;
    legal = 1'b0;
    mis   = 1'b0;
    case (funct3)
      F3_B:  legal = 1'b1;
      F3_H:  begin legal = 1'b1; mis = addr_lo[0]; end
      F3_W:  begin legal = 1'b1; mis = |addr_lo;   end
      F3_BU: legal = !we;
      F3_HU: begin legal = !we;  mis = addr_lo[0]; end
      default: legal = 1'b0;
    endcase
    return !legal || mis;
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Combinational load-data extractor: picks the byte/halfword lane and sign- or zero-extends it.
// Zero latency, no flow control.
module lsu_load_align
  import lsu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        addr,
  input  logic [2:0]        funct3,
  output logic [DATA_W-1:0] ext_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata[{addr, 3'b000} +: 8];
    half_sel = rdata[{addr[1], 4'b0000} +: 16];
    case (funct3)
      F3_B:    ext_data = {{(DATA_W-8){byte_sel[7]}}, byte_sel};
      F3_H:    ext_data = {{(DATA_W-16){half_sel[15]}}, half_sel};
      F3_BU:   ext_data = {{(DATA_W-8){1'b0}}, byte_sel};
      F3_HU:   ext_data = {{(DATA_W-16){1'b0}}, half_sel};
      default: ext_data = rdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit: store responds 2 cycles after accept, load 2+MEM_LAT.
// req_ready only in IDLE; a response is held in RESP until resp_ready.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [DM_ADDRESS-1:0] req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  input  logic [2:0]            req_funct3,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_W-1:0]     resp_rdata,
  output logic                  resp_err,
  output logic [DM_ADDRESS-1:0] mem_addr,
  output logic                  mem_re,
  output logic [3:0]            mem_wr,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic [DATA_W-1:0]     mem_rdata
);

  localparam logic [2:0] CNT_LAST = 3'(MEM_LAT - 1);

  lsu_state_e            state_q, state_d;
  logic                  we_q, we_d;
  logic [DM_ADDRESS-1:0] addr_q, addr_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;
  logic [2:0]            f3_q, f3_d;
  logic [2:0]            cnt_q, cnt_d;
  logic [DATA_W-1:0]     rdata_q, rdata_d;
  logic                  err_q, err_d;

  logic                  acc_err;
  logic [DATA_W-1:0]     ld_ext;

  assign acc_err = lsu_access_err(we_q, f3_q, addr_q[1:0]);

  lsu_load_align #(.DATA_W(DATA_W)) u_load_align (
    .rdata    (mem_rdata),
    .addr     (addr_q[1:0]),
    .funct3   (f3_q),
    .ext_data (ld_ext)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      f3_q    <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      f3_q    <= f3_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    f3_d    = f3_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          f3_d    = req_funct3;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_d   = '0;
        rdata_d = '0;
        err_d   = acc_err;
        state_d = (acc_err || we_q) ? S_RESP : S_WAIT;
      end
      S_WAIT: begin
        // mem_rdata is valid exactly MEM_LAT cycles after the ISSUE cycle.
        if (cnt_q == CNT_LAST) begin
          rdata_d = ld_ext;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      S_RESP: begin
        if (resp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready  = (state_q == S_IDLE);
    resp_valid = (state_q == S_RESP);
    resp_rdata = resp_valid ? rdata_q : '0;
    resp_err   = resp_valid && err_q;
    mem_addr   = '0;
    mem_re     = 1'b0;
    mem_wr     = 4'b0000;
    mem_wdata  = '0;
    case (state_q)
      S_ISSUE: begin
        mem_addr = {addr_q[DM_ADDRESS-1:2], 2'b00};
        if (!acc_err) begin
          if (we_q) begin
            case (f3_q[1:0])
              2'b00: begin
                mem_wr    = 4'b0001 << addr_q[1:0];
                mem_wdata = {(DATA_W/8){wdata_q[7:0]}};
              end
              2'b01: begin
                mem_wr    = 4'b0011 << {addr_q[1], 1'b0};
                mem_wdata = {(DATA_W/16){wdata_q[15:0]}};
              end
              default: begin
                mem_wr    = 4'b1111;
                mem_wdata = wdata_q;
              end
            endcase
          end else begin
            mem_re = 1'b1;
          end
        end
      end
      S_WAIT: mem_addr = {addr_q[DM_ADDRESS-1:2], 2'b00};
      default: ;
    endcase
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: two instances (MEM_LAT=1 and MEM_LAT=3) against a transaction-level model.
module tb_load_store_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        req_valid [2];
  logic        req_we [2];
  logic        resp_ready [2];
  logic [8:0]  req_addr [2];
  logic [31:0] req_wdata [2];
  logic [2:0]  req_funct3 [2];
  logic        req_ready [2];
  logic        resp_valid [2];
  logic        resp_err [2];
  logic        mem_re [2];
  logic [31:0] resp_rdata [2];
  logic [31:0] mem_wdata [2];
  logic [31:0] mem_rdata [2];
  logic [8:0]  mem_addr [2];
  logic [3:0]  mem_wr [2];

  logic [31:0] mem [128];
  logic [31:0] rp0;
  logic [31:0] rp1 [3];

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  load_store_unit #(.DM_ADDRESS(9), .DATA_W(32), .MEM_LAT(1)) u_dut0 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_funct3(req_funct3[0]),
    .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]), .resp_rdata(resp_rdata[0]),
    .resp_err(resp_err[0]), .mem_addr(mem_addr[0]), .mem_re(mem_re[0]),
    .mem_wr(mem_wr[0]), .mem_wdata(mem_wdata[0]), .mem_rdata(mem_rdata[0])
  );

  load_store_unit #(.DM_ADDRESS(9), .DATA_W(32), .MEM_LAT(3)) u_dut1 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_funct3(req_funct3[1]),
    .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]), .resp_rdata(resp_rdata[1]),
    .resp_err(resp_err[1]), .mem_addr(mem_addr[1]), .mem_re(mem_re[1]),
    .mem_wr(mem_wr[1]), .mem_wdata(mem_wdata[1]), .mem_rdata(mem_rdata[1])
  );

  // Memory returns the addressed word MEM_LAT cycles after a read strobe, garbage otherwise.
  always @(posedge clk) begin
    rp0    <= mem_re[0] ? mem[mem_addr[0][8:2]] : 32'hDEADBEEF;
    rp1[0] <= mem_re[1] ? mem[mem_addr[1][8:2]] : 32'hDEADBEEF;
    rp1[1] <= rp1[0];
    rp1[2] <= rp1[1];
  end
  assign mem_rdata[0] = rp0;
  assign mem_rdata[1] = rp1[2];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cyc %0d: got 0x%08h, want 0x%08h", nm, cyc, act, exp);
    end
  endtask

  function automatic int lat_of(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  // Transaction model: one outstanding request per instance, expectations derived at acceptance.
  bit          busy [2];
  int          acc [2];
  logic        m_we [2];
  logic        m_err [2];
  logic [8:0]  m_addr [2];
  logic [3:0]  m_wr [2];
  logic [31:0] m_wd [2];
  logic [31:0] m_rd [2];
  int          m_rk [2];

  task automatic model_accept(input int i);
    logic [8:0]  a;
    logic [2:0]  f;
    logic [31:0] w, v;
    int          sz, lane;
    bit          legal;
    a  = req_addr[i];
    f  = req_funct3[i];
    w  = req_wdata[i];
    sz = int'(f[1:0]);
    lane = int'(a) % 4;
    legal = req_we[i] ? (f <= 3'd2) : (f <= 3'd2 || f == 3'd4 || f == 3'd5);
    m_err[i]  = !legal || (sz == 1 && lane % 2 != 0) || (sz == 2 && lane != 0);
    m_we[i]   = req_we[i];
    m_addr[i] = a & 9'h1FC;
    m_wr[i]   = (sz == 0) ? 4'(1 << lane) : (sz == 1) ? 4'(3 << (lane / 2 * 2)) : 4'hF;
    m_wd[i]   = (sz == 0) ? (w & 32'hFF) * 32'h01010101 :
                (sz == 1) ? (w & 32'hFFFF) * 32'h00010001 : w;
    v = mem[a / 4];
    if (sz == 0) begin
      v = (v >> (8 * lane)) & 32'hFF;
      if (f == 3'd0 && v >= 32'd128) v = v - 32'd256;
    end else if (sz == 1) begin
      v = (v >> (16 * (lane / 2))) & 32'hFFFF;
      if (f == 3'd1 && v >= 32'd32768) v = v - 32'd65536;
    end
    m_rd[i] = (m_err[i] || m_we[i]) ? 32'd0 : v;
    m_rk[i] = (m_err[i] || m_we[i]) ? 2 : 2 + lat_of(i);
  endtask

  task automatic cmp_inst(input int i);
    int k;
    if (reset) begin
      busy[i] = 1'b0;
      return;
    end
    chk("vld_rdy_exclusive", 32'(resp_valid[i] && req_ready[i]), 32'd0);
    if (!busy[i]) begin
      chk("idle_req_ready", 32'(req_ready[i]), 32'd1);
      chk("idle_resp_valid", 32'(resp_valid[i]), 32'd0);
      chk("idle_mem_re", 32'(mem_re[i]), 32'd0);
      chk("idle_mem_wr", 32'(mem_wr[i]), 32'd0);
      chk("idle_mem_wdata", mem_wdata[i], 32'd0);
      if (req_valid[i]) begin
        model_accept(i);
        busy[i] = 1'b1;
        acc[i]  = cyc;
      end
    end else begin
      k = cyc - acc[i];
      if (k < m_rk[i]) begin
        chk("busy_resp_valid", 32'(resp_valid[i]), 32'd0);
        chk("busy_req_ready", 32'(req_ready[i]), 32'd0);
        chk("busy_mem_addr", 32'(mem_addr[i]), 32'(m_addr[i]));
      end
      if (k == 1) begin
        chk("issue_mem_re", 32'(mem_re[i]), 32'(!m_err[i] && !m_we[i]));
        chk("issue_mem_wr", 32'(mem_wr[i]), (m_err[i] || !m_we[i]) ? 32'd0 : 32'(m_wr[i]));
        if (m_we[i] && !m_err[i]) chk("issue_mem_wdata", mem_wdata[i], m_wd[i]);
      end else if (k < m_rk[i]) begin
        chk("wait_mem_re", 32'(mem_re[i]), 32'd0);
        chk("wait_mem_wr", 32'(mem_wr[i]), 32'd0);
      end else begin
        chk("resp_valid", 32'(resp_valid[i]), 32'd1);
        chk("resp_rdata", resp_rdata[i], m_rd[i]);
        chk("resp_err", 32'(resp_err[i]), 32'(m_err[i]));
        chk("resp_req_ready", 32'(req_ready[i]), 32'd0);
        chk("resp_mem_re", 32'(mem_re[i]), 32'd0);
        chk("resp_mem_wr", 32'(mem_wr[i]), 32'd0);
        chk("resp_mem_wdata", mem_wdata[i], 32'd0);
        if (resp_ready[i]) busy[i] = 1'b0;
      end
    end
  endtask

  always @(negedge clk) begin
    cyc++;
    for (int i = 0; i < 2; i++) cmp_inst(i);
  end

  // Issue one request and check the hand-computed response, latency and stall behaviour.
  task automatic run(input int id, input logic we, input logic [8:0] a, input logic [31:0] wd,
                     input logic [2:0] f3, input logic [31:0] exp_d, input logic exp_e,
                     input int exp_lat, input int stall,
                     output logic [3:0] o_wr, output logic [31:0] o_wd, output logic [8:0] o_addr);
    int n;
    bit seen;
    req_we[id] = we; req_addr[id] = a; req_wdata[id] = wd; req_funct3[id] = f3;
    req_valid[id] = 1'b1;
    resp_ready[id] = (stall == 0);
    n = 0;
    while (!req_ready[id] && n < 20) begin @(posedge clk); #1; n++; end
    chk("accept_ready", 32'(req_ready[id]), 32'd1);
    @(posedge clk); #1;
    req_valid[id] = 1'b0;
    o_wr = mem_wr[id]; o_wd = mem_wdata[id]; o_addr = mem_addr[id];
    n = 1;
    seen = 1'b0;
    while (!seen && n < 40) begin
      if (resp_valid[id]) seen = 1'b1;
      else begin @(posedge clk); #1; n++; end
    end
    chk("dir_latency", 32'(n), 32'(exp_lat));
    chk("dir_rdata", resp_rdata[id], exp_d);
    chk("dir_err", 32'(resp_err[id]), 32'(exp_e));
    repeat (stall) begin
      @(posedge clk); #1;
      chk("stall_valid", 32'(resp_valid[id]), 32'd1);
      chk("stall_rdata", resp_rdata[id], exp_d);
      chk("stall_err", 32'(resp_err[id]), 32'(exp_e));
      chk("stall_req_ready", 32'(req_ready[id]), 32'd0);
    end
    resp_ready[id] = 1'b1;
    @(posedge clk); #1;
    chk("back_to_idle", 32'(req_ready[id]), 32'd1);
    chk("idle_after_resp", 32'(resp_valid[id]), 32'd0);
  endtask

  initial begin
    #400000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0]  ow;
    logic [31:0] od;
    logic [8:0]  oa;
    for (int i = 0; i < 128; i++) mem[i] = 32'h13579BDF ^ (i * 32'h01010101);
    mem[0] = 32'hBEEF1234;
    mem[1] = 32'h80112233;
    mem[2] = 32'h7F00FF01;
    for (int i = 0; i < 2; i++) begin
      req_valid[i] = 1'b0; req_we[i] = 1'b0; req_addr[i] = '0;
      req_wdata[i] = '0; req_funct3[i] = '0; resp_ready[i] = 1'b1;
    end
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk("rst_req_ready", 32'(req_ready[i]), 32'd1);
      chk("rst_resp_valid", 32'(resp_valid[i]), 32'd0);
      chk("rst_resp_rdata", resp_rdata[i], 32'd0);
      chk("rst_resp_err", 32'(resp_err[i]), 32'd0);
      chk("rst_mem_addr", 32'(mem_addr[i]), 32'd0);
      chk("rst_mem_re", 32'(mem_re[i]), 32'd0);
      chk("rst_mem_wr", 32'(mem_wr[i]), 32'd0);
      chk("rst_mem_wdata", mem_wdata[i], 32'd0);
    end

    run(0, 1'b1, 9'h006, 32'h000000A5, 3'b000, 32'h0, 1'b0, 2, 0, ow, od, oa);
    chk("sb_mem_wr", 32'(ow), 32'h4);
    chk("sb_mem_wdata", od, 32'hA5A5A5A5);
    chk("sb_mem_addr", 32'(oa), 32'h004);
    run(0, 1'b0, 9'h007, 32'h0, 3'b000, 32'hFFFFFF80, 1'b0, 3, 0, ow, od, oa);
    chk("lb_mem_wr", 32'(ow), 32'h0);
    run(0, 1'b0, 9'h007, 32'h0, 3'b100, 32'h00000080, 1'b0, 3, 0, ow, od, oa);
    run(0, 1'b0, 9'h002, 32'h0, 3'b001, 32'hFFFFBEEF, 1'b0, 3, 0, ow, od, oa);
    run(0, 1'b0, 9'h002, 32'h0, 3'b101, 32'h0000BEEF, 1'b0, 3, 0, ow, od, oa);
    run(0, 1'b0, 9'h000, 32'h0, 3'b010, 32'hBEEF1234, 1'b0, 3, 0, ow, od, oa);
    run(0, 1'b1, 9'h00A, 32'h11223344, 3'b010, 32'h0, 1'b1, 2, 0, ow, od, oa);
    chk("sw_mis_mem_wr", 32'(ow), 32'h0);
    run(0, 1'b0, 9'h000, 32'h0, 3'b011, 32'h0, 1'b1, 2, 0, ow, od, oa);
    run(0, 1'b1, 9'h00A, 32'h1234CDEF, 3'b001, 32'h0, 1'b0, 2, 0, ow, od, oa);
    chk("sh_mem_wr", 32'(ow), 32'hC);
    chk("sh_mem_wdata", od, 32'hCDEFCDEF);
    chk("sh_mem_addr", 32'(oa), 32'h008);
    run(0, 1'b0, 9'h003, 32'h0, 3'b001, 32'h0, 1'b1, 2, 0, ow, od, oa);
    run(0, 1'b0, 9'h006, 32'h0, 3'b010, 32'h0, 1'b1, 2, 0, ow, od, oa);
    run(0, 1'b1, 9'h004, 32'h0, 3'b100, 32'h0, 1'b1, 2, 0, ow, od, oa);
    run(0, 1'b0, 9'h00A, 32'h0, 3'b000, 32'h00000000, 1'b0, 3, 0, ow, od, oa);
    run(0, 1'b0, 9'h009, 32'h0, 3'b100, 32'h000000FF, 1'b0, 3, 0, ow, od, oa);
    run(0, 1'b0, 9'h009, 32'h0, 3'b000, 32'hFFFFFFFF, 1'b0, 3, 0, ow, od, oa);
    run(0, 1'b0, 9'h00A, 32'h0, 3'b001, 32'h00007F00, 1'b0, 3, 0, ow, od, oa);
    run(0, 1'b0, 9'h004, 32'h0, 3'b010, 32'h80112233, 1'b0, 3, 5, ow, od, oa);
    run(0, 1'b1, 9'h010, 32'hCAFEF00D, 3'b010, 32'h0, 1'b0, 2, 0, ow, od, oa);
    chk("sw_mem_wr", 32'(ow), 32'hF);
    chk("sw_mem_wdata", od, 32'hCAFEF00D);

    run(1, 1'b0, 9'h004, 32'h0, 3'b010, 32'h80112233, 1'b0, 5, 0, ow, od, oa);
    req_we[1] = 1'b0; req_addr[1] = 9'h004; req_funct3[1] = 3'b010; req_valid[1] = 1'b1;
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    @(posedge clk); #1;
    chk("abort_in_wait_ready", 32'(req_ready[1]), 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("abort_idle_ready", 32'(req_ready[1]), 32'd1);
    chk("abort_no_resp", 32'(resp_valid[1]), 32'd0);
    repeat (8) begin
      @(posedge clk); #1;
      chk("abort_silent_valid", 32'(resp_valid[1]), 32'd0);
      chk("abort_silent_re", 32'(mem_re[1]), 32'd0);
    end
    run(1, 1'b0, 9'h007, 32'h0, 3'b000, 32'hFFFFFF80, 1'b0, 5, 0, ow, od, oa);
    run(0, 1'b0, 9'h007, 32'h0, 3'b000, 32'hFFFFFF80, 1'b0, 3, 0, ow, od, oa);

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter DM_ADDRESS, default 9, is the byte-address width.
REQ-002 Parameter DATA_W, default 32, is the data width.
REQ-003 Parameter MEM_LAT, default 1, is the number of cycles from read address to valid mem_rdata; legal range is 1..7.
REQ-004 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-005 Port reset, input, 1 bit: reset is synchronous and active-high.
REQ-006 Port req_valid, input, 1 bit: a pipeline request is present.
REQ-007 Port req_ready, output, 1 bit: the unit accepts a request.
REQ-008 Port req_we, input, 1 bit: 1 selects a store, 0 selects a load.
REQ-009 Port req_addr, input, DM_ADDRESS bits: byte address.
REQ-010 Port req_wdata, input, DATA_W bits: store data.
REQ-011 Port req_funct3, input, 3 bits: access size and signedness.
REQ-012 Port resp_valid, output, 1 bit: a response is present.
REQ-013 Port resp_ready, input, 1 bit: the consumer accepts the response.
REQ-014 Port resp_rdata, output, DATA_W bits: aligned and extended load data.
REQ-015 Port resp_err, output, 1 bit: the access was misaligned or used an illegal funct3.
REQ-016 Port mem_addr, output, DM_ADDRESS bits: word-aligned memory address.
REQ-017 Port mem_re, output, 1 bit: memory read strobe.
REQ-018 Port mem_wr, output, 4 bits: byte-lane write enables.
REQ-019 Port mem_wdata, output, DATA_W bits: lane-positioned write data.
REQ-020 Port mem_rdata, input, DATA_W bits: memory read word.

Function
REQ-021 The FSM SHALL have the states IDLE, ISSUE, WAIT and RESP; req_ready SHALL equal 1 only in IDLE.
REQ-022 In IDLE, when req_valid && req_ready, the unit SHALL latch req_we, req_addr, req_wdata and req_funct3, then go to ISSUE; otherwise it SHALL stay in IDLE.
REQ-023 Legal loads SHALL be funct3 000 LB, 001 LH, 010 LW, 100 LBU and 101 LHU; legal stores SHALL be 000 SB, 001 SH and 010 SW; any other funct3 is illegal.
REQ-024 Misalignment SHALL be defined as halfword with addr[0]=1, or word with addr[1:0]!=0.
REQ-025 A misaligned or illegal access SHALL go from ISSUE to RESP with no memory activity (mem_re=0, mem_wr=0), resp_err=1 and resp_rdata=0.
REQ-026 In ISSUE, mem_addr SHALL be {addr[DM_ADDRESS-1:2],2'b00} for exactly one cycle.
- Store: mem_wr SHALL be SB 4'b0001<<addr[1:0], SH 4'b0011<<{addr[1],1'b0}, SW 4'b1111.
- Store: mem_wdata SHALL be the byte replicated ×4, the halfword replicated ×2, or the word.
- Load: mem_re=1 and mem_wr=0.
REQ-027 A store SHALL go from ISSUE to RESP; a load SHALL go from ISSUE to WAIT.
REQ-028 WAIT SHALL hold mem_addr, count MEM_LAT cycles, capture mem_rdata on the last count, then go to RESP.
REQ-029 Load data extraction:
- Byte load: select byte addr[1:0].
- Halfword load: select halfword addr[1].
- LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
REQ-030 In RESP, resp_valid=1 with resp_rdata and resp_err stable; the state SHALL return to IDLE on the cycle resp_ready=1.
REQ-031 A store response SHALL have resp_rdata=0.
REQ-032 Latency with resp_ready=1: store response 2 cycles after acceptance; load response 2+MEM_LAT cycles after acceptance; the next request is accepted the cycle after RESP.
REQ-033 resp_valid and req_ready SHALL never both be 1.
REQ-034 Outside ISSUE and WAIT, mem_re=0, mem_wr=0 and mem_wdata=0.

Reset
REQ-035 When reset=1 at a clock edge, the state SHALL become IDLE and the WAIT counter 0; this SHALL abort any access in progress, with no further mem_wr or mem_re asserted.
REQ-036 After reset: req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, mem_addr=0, mem_re=0, mem_wr=0, mem_wdata=0.

Structure
REQ-037 A shared package lsu_pkg SHALL hold:
- the state enum;
- the funct3 constants F3_B=000, F3_H=001, F3_W=010, F3_BU=100, F3_HU=101.
REQ-038 One sub-module, lsu_load_align, SHALL be purely combinational: inputs rdata, addr[1:0] and funct3; output the extended word.

Verification
REQ-039 SB: addr=0x006, wdata=0x000000A5 -> one ISSUE cycle, mem_addr=0x004, mem_wr=0100, mem_wdata=0xA5A5A5A5; resp_valid 2 cycles after acceptance, resp_err=0.
REQ-040 LB: addr=0x007, mem_rdata=0x80112233, MEM_LAT=1 -> resp_rdata=0xFFFFFF80 at acceptance+3.
- LBU, same address and data -> 0x00000080.
REQ-041 LH: addr=0x002, mem_rdata=0xBEEF1234 -> 0xFFFFBEEF.
- LHU -> 0x0000BEEF.
- LW at 0x000 -> 0xBEEF1234.
REQ-042 SW: addr=0x00A -> resp_err=1, resp_rdata=0, mem_wr=0 in every cycle.
- funct3=011 load -> resp_err=1.
REQ-043 resp_ready held 0 for 5 cycles -> resp_valid stays 1 with stable data and req_ready=0; release -> IDLE the next cycle, and a back-to-back request is accepted.
REQ-044 Reset asserted in WAIT of a load with MEM_LAT=3 -> next cycle IDLE, resp_valid=0, and no response ever appears for the aborted load.
